// File: rtl/addr_seq_engine.sv
// addr_seq_engine
//   Drains the driver address FIFO while a program is active and issues
//   vector-memory addresses downstream over a valid/ready handshake. Each FIFO
//   word is a base address. In consecutive mode the base is expanded into a
//   burst of consec_count+1 addresses spaced ADDR_STEP apart. Cycle and issue
//   counters are kept for status readback.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for run_program; counters hold for readback
//   FETCH   | pop one FIFO word, or finish on empty+end, or abort
//   LOAD    | FIFO data valid: capture base address and burst length
//   ISSUE   | present vec_addr until accepted, step through the burst
//   DONE    | one-cycle seq_done pulse, then back to IDLE
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   run_program                start request (IDLE only)
//   end_program                finish once the FIFO is empty between bursts
//   abort_program              terminate from any non-IDLE state
//   freeze_addr_fifo           hold off FIFO reads (bursts continue)
//   send_consec_addr           enable burst expansion
//   consec_count[7:0]          extra addresses per base
//   addr_fifo_dout/empty/rd    FIFO read port (data one cycle after rd)
//   vec_addr/valid/ready       downstream address handshake
//   seq_busy, seq_done         status flags
//   addr_cycle_cnt             non-IDLE cycles in the current run
//   addr_issue_cnt             addresses accepted in the current run
module addr_seq_engine #(
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_program,
  input  logic              end_program,
  input  logic              abort_program,
  input  logic              freeze_addr_fifo,
  input  logic              send_consec_addr,
  input  logic [7:0]        consec_count,
  input  logic [ADDR_W-1:0] addr_fifo_dout,
  input  logic              addr_fifo_empty,
  output logic              addr_fifo_rd,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              vec_addr_valid,
  input  logic              vec_addr_ready,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [CNT_W-1:0]  addr_cycle_cnt,
  output logic [CNT_W-1:0]  addr_issue_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_t     state;
  logic [7:0] remaining;
  logic       fetch_go;
  logic       accept;

  // The read strobe and valid are decoded in the same cycle as the deciding
  // inputs: the FIFO pop must happen in the FETCH cycle itself, and an abort
  // must pull valid down before the address can be taken.
  assign fetch_go       = (state == S_FETCH) && !abort_program &&
                          !addr_fifo_empty && !freeze_addr_fifo;
  assign addr_fifo_rd   = fetch_go;
  assign vec_addr_valid = (state == S_ISSUE) && !abort_program;
  assign accept         = vec_addr_valid && vec_addr_ready;
  assign seq_busy       = (state != S_IDLE);
  assign seq_done       = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      remaining      <= '0;
      vec_addr       <= '0;
      addr_cycle_cnt <= '0;
      addr_issue_cnt <= '0;
    end else begin
      if (state != S_IDLE) begin
        if (addr_cycle_cnt != '1)
          addr_cycle_cnt <= addr_cycle_cnt + CNT_W'(1);
        if (accept && (addr_issue_cnt != '1))
          addr_issue_cnt <= addr_issue_cnt + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (run_program) begin
            addr_cycle_cnt <= '0;
            addr_issue_cnt <= '0;
            state          <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (abort_program)
            state <= S_DONE;
          else if (fetch_go)
            state <= S_LOAD;
          else if (addr_fifo_empty && end_program)
            state <= S_DONE;
        end
        S_LOAD: begin
          // Burst controls are latched here so mid-burst changes are ignored.
          vec_addr  <= addr_fifo_dout;
          remaining <= send_consec_addr ? consec_count : 8'd0;
          state     <= abort_program ? S_DONE : S_ISSUE;
        end
        S_ISSUE: begin
          if (abort_program) begin
            state <= S_DONE;
          end else if (accept) begin
            if (remaining == 8'd0) begin
              state <= S_FETCH;
            end else begin
              vec_addr  <= vec_addr + STEP;
              remaining <= remaining - 8'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_seq_engine.sv
module tb_addr_seq_engine;
  localparam int TMAX = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_program = 1'b0;
  logic        end_program = 1'b0;
  logic        abort_program = 1'b0;
  logic        freeze_addr_fifo = 1'b0;
  logic        send_consec_addr = 1'b0;
  logic [7:0]  consec_count = 8'd0;
  logic [31:0] fifo_dout = 32'd0;
  logic        addr_fifo_empty;
  logic        addr_fifo_rd;
  logic [31:0] vec_addr;
  logic        vec_addr_valid;
  logic        vec_addr_ready;
  logic        seq_busy;
  logic        seq_done;
  logic [15:0] addr_cycle_cnt;
  logic [15:0] addr_issue_cnt;

  addr_seq_engine dut (
    .clk              (clk),
    .reset            (reset),
    .run_program      (run_program),
    .end_program      (end_program),
    .abort_program    (abort_program),
    .freeze_addr_fifo (freeze_addr_fifo),
    .send_consec_addr (send_consec_addr),
    .consec_count     (consec_count),
    .addr_fifo_dout   (fifo_dout),
    .addr_fifo_empty  (addr_fifo_empty),
    .addr_fifo_rd     (addr_fifo_rd),
    .vec_addr         (vec_addr),
    .vec_addr_valid   (vec_addr_valid),
    .vec_addr_ready   (vec_addr_ready),
    .seq_busy         (seq_busy),
    .seq_done         (seq_done),
    .addr_cycle_cnt   (addr_cycle_cnt),
    .addr_issue_cnt   (addr_issue_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: words written by the stimulus, popped on rd with data one cycle later.
  logic [31:0] fmem [TMAX];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic fifo_flush = 1'b0;
  assign addr_fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_flush)
      rd_ptr <= wr_ptr;
    else if (addr_fifo_rd && (rd_ptr != wr_ptr)) begin
      fifo_dout <= fmem[rd_ptr % TMAX];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Ready: directed value, or per-address stall counts in random mode.
  logic dir_ready = 1'b0;
  logic rnd_ready = 1'b1;
  logic rdy_mode = 1'b0;
  int   st_mem [TMAX];
  int   st_wr = 0;
  int   st_rd = 0;
  int   cur_stall = 0;
  bit   stall_live = 1'b0;
  assign vec_addr_ready = rdy_mode ? rnd_ready : dir_ready;
  always @(negedge clk) begin
    #3;
    if (rdy_mode && vec_addr_valid) begin
      if (!stall_live) begin
        if (st_rd < st_wr) begin
          cur_stall = st_mem[st_rd % TMAX];
          st_rd = st_rd + 1;
        end else
          cur_stall = 0;
        stall_live = 1'b1;
      end
      if (cur_stall > 0) begin
        rnd_ready = 1'b0;
        cur_stall = cur_stall - 1;
      end else begin
        rnd_ready  = 1'b1;
        stall_live = 1'b0;
      end
    end else
      rnd_ready = 1'($urandom_range(0, 1));
  end

  // Per-cycle trace sampled just before the active edge.
  logic        tr_rd [TMAX];
  logic        tr_emp [TMAX];
  logic        tr_val [TMAX];
  logic        tr_rdy [TMAX];
  logic        tr_done [TMAX];
  logic [31:0] tr_addr [TMAX];
  logic [15:0] tr_cyc [TMAX];
  int cyc = 0;
  always @(negedge clk) begin
    #4;
    if (cyc < TMAX) begin
      tr_rd[cyc]   = addr_fifo_rd;
      tr_emp[cyc]  = addr_fifo_empty;
      tr_val[cyc]  = vec_addr_valid;
      tr_rdy[cyc]  = vec_addr_ready;
      tr_done[cyc] = seq_done;
      tr_addr[cyc] = vec_addr;
      tr_cyc[cyc]  = addr_cycle_cnt;
    end
    cyc = cyc + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] acc_q [$];
  int acc_idx [$];
  int n_rd, n_done, n_unstable, n_rd_empty, n_stall, first_rd, first_val;
  int c0, v, rc;

  task scan(input int a, input int b);
    acc_q.delete();
    acc_idx.delete();
    n_rd = 0; n_done = 0; n_unstable = 0; n_rd_empty = 0; n_stall = 0;
    first_rd = -1; first_val = -1;
    for (int i = a; i < b; i++) begin
      if (tr_rd[i]) begin
        n_rd++;
        if (first_rd < 0) first_rd = i;
      end
      if (tr_rd[i] && tr_emp[i]) n_rd_empty++;
      if (tr_done[i]) n_done++;
      if (tr_val[i] && first_val < 0) first_val = i;
      if (tr_val[i] && tr_rdy[i]) begin
        acc_q.push_back(tr_addr[i]);
        acc_idx.push_back(i);
      end
      if (tr_val[i] && !tr_rdy[i]) begin
        n_stall++;
        if (i + 1 < b && tr_val[i+1] && tr_addr[i+1] !== tr_addr[i]) n_unstable++;
      end
    end
  endtask

  task cmp_addrs(input string tag);
    chk({tag, "_count"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
      chk({tag, "_addr"}, acc_q[i], exp_q[i]);
  endtask

  task adv;
    @(negedge clk);
    #2;
  endtask

  task idle_setup;
    run_program = 1'b0; end_program = 1'b0; abort_program = 1'b0;
    freeze_addr_fifo = 1'b0; send_consec_addr = 1'b0; consec_count = 8'd0;
    rdy_mode = 1'b0; dir_ready = 1'b0;
  endtask

  task push(input logic [31:0] a);
    fmem[wr_ptr % TMAX] = a;
    wr_ptr = wr_ptr + 1;
  endtask

  task start_run;
    adv;
    run_program = 1'b1;
    c0 = cyc;
    adv;
    run_program = 1'b0;
  endtask

  task wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    while (seq_busy && n < limit) begin
      adv;
      n++;
    end
    if (seq_busy) chk(tag, seq_busy, 1'b0);
  endtask

  task wait_valid(input int limit, input string tag);
    int n;
    n = 0;
    while (!vec_addr_valid && n < limit) begin
      adv;
      n++;
    end
    if (!vec_addr_valid) chk(tag, vec_addr_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, len, s, ecyc;
    logic [31:0] base;

    // Reset state
    idle_setup;
    repeat (2) adv;
    chk("rst_busy", seq_busy, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_valid", vec_addr_valid, 0);
    chk("rst_rd", addr_fifo_rd, 0);
    chk("rst_addr", vec_addr, 0);
    chk("rst_cyc", addr_cycle_cnt, 0);
    chk("rst_iss", addr_issue_cnt, 0);
    reset = 1'b1;
    adv;

    // Basic drain, end_program held from the start
    push(32'h1000); push(32'h2000);
    dir_ready = 1'b1; end_program = 1'b1;
    start_run;
    wait_idle(100, "t1_timeout");
    scan(c0, cyc);
    exp_q = '{32'h1000, 32'h2000};
    cmp_addrs("t1");
    chk("t1_run_to_rd", first_rd - c0, 1);
    chk("t1_rd_to_valid", first_val - first_rd, 2);
    chk("t1_rd_count", n_rd, 2);
    chk("t1_done_count", n_done, 1);
    chk("t1_done_last", tr_done[cyc-1], 1);
    if (acc_idx.size() == 2) chk("t1_burst_gap", acc_idx[1] - acc_idx[0], 3);
    chk("t1_issue_cnt", addr_issue_cnt, 2);
    chk("t1_cycle_cnt", addr_cycle_cnt, 8);
    idle_setup;

    // Burst of 4; controls changed mid-burst must not matter
    push(32'h0000_0100);
    send_consec_addr = 1'b1; consec_count = 8'd3; dir_ready = 1'b1; end_program = 1'b1;
    start_run;
    wait_valid(20, "t2_valid_timeout");
    send_consec_addr = 1'b0; consec_count = 8'd0;
    wait_idle(100, "t2_timeout");
    scan(c0, cyc);
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    cmp_addrs("t2");
    if (acc_idx.size() == 4) chk("t2_back_to_back", acc_idx[3] - acc_idx[0], 3);
    chk("t2_issue_cnt", addr_issue_cnt, 4);
    idle_setup;

    // Backpressure and address wrap
    push(32'hFFFF_FFFC);
    send_consec_addr = 1'b1; consec_count = 8'd1; dir_ready = 1'b0; end_program = 1'b1;
    start_run;
    wait_valid(20, "t3_valid_timeout");
    v = cyc;
    repeat (5) adv;
    dir_ready = 1'b1;
    wait_idle(100, "t3_timeout");
    scan(c0, cyc);
    exp_q = '{32'hFFFF_FFFC, 32'h0000_0000};
    cmp_addrs("t3");
    chk("t3_stall_cycles", n_stall, 5);
    chk("t3_unstable", n_unstable, 0);
    chk("t3_held_addr", tr_addr[v], 32'hFFFF_FFFC);
    if (acc_idx.size() == 2) chk("t3_accept_at", acc_idx[0] - v, 5);
    idle_setup;

    // Freeze for 10 cycles in FETCH
    push(32'h0000_00A0);
    freeze_addr_fifo = 1'b1; dir_ready = 1'b1;
    start_run;
    repeat (9) adv;
    adv;
    freeze_addr_fifo = 1'b0;
    adv;
    end_program = 1'b1;
    wait_idle(100, "t4_timeout");
    scan(c0, c0 + 11);
    chk("t4_frozen_rd", n_rd, 0);
    chk("t4_frozen_valid", first_val, -1);
    chk("t4_cyc_start", tr_cyc[c0+1], 0);
    chk("t4_cyc_after_freeze", tr_cyc[c0+11], 10);
    chk("t4_rd_on_release", tr_rd[c0+11], 1);
    scan(c0, cyc);
    exp_q = '{32'h0000_00A0};
    cmp_addrs("t4");
    idle_setup;

    // Abort after two accepts of an 8-address burst
    push(32'h0000_4000);
    send_consec_addr = 1'b1; consec_count = 8'd7; dir_ready = 1'b1;
    start_run;
    wait_valid(20, "t5_valid_timeout");
    v = cyc;
    adv;
    adv;
    abort_program = 1'b1;
    adv;
    abort_program = 1'b0;
    wait_idle(100, "t5_timeout");
    scan(c0, cyc);
    exp_q = '{32'h4000, 32'h4004};
    cmp_addrs("t5");
    chk("t5_valid_before_abort", tr_val[v+1], 1);
    chk("t5_valid_on_abort", tr_val[v+2], 0);
    chk("t5_done_next", tr_done[v+3], 1);
    chk("t5_done_count", n_done, 1);
    chk("t5_issue_cnt", addr_issue_cnt, 2);
    idle_setup;

    // Asynchronous reset in the middle of a burst
    push(32'h0000_5000);
    send_consec_addr = 1'b1; consec_count = 8'd5; dir_ready = 1'b0; end_program = 1'b1;
    start_run;
    wait_valid(20, "t6_valid_timeout");
    #1;
    reset = 1'b0;
    #1;
    rc = cyc;
    chk("t6_valid", vec_addr_valid, 0);
    chk("t6_busy", seq_busy, 0);
    chk("t6_addr", vec_addr, 0);
    chk("t6_cyc", addr_cycle_cnt, 0);
    chk("t6_iss", addr_issue_cnt, 0);
    adv;
    adv;
    reset = 1'b1;
    fifo_flush = 1'b1;
    adv;
    fifo_flush = 1'b0;
    adv;
    scan(rc, cyc);
    chk("t6_no_done", n_done, 0);
    idle_setup;
    push(32'h0000_6000);
    dir_ready = 1'b1; end_program = 1'b1;
    start_run;
    wait_idle(100, "t6b_timeout");
    scan(c0, cyc);
    exp_q = '{32'h0000_6000};
    cmp_addrs("t6b");
    chk("t6b_issue_cnt", addr_issue_cnt, 1);
    chk("t6b_cycle_cnt", addr_cycle_cnt, 5);
    chk("t6b_done_count", n_done, 1);
    idle_setup;

    // Randomized runs: FIFO preloaded, end_program held, random per-address stalls
    for (int r = 0; r < 25; r++) begin
      idle_setup;
      nb = $urandom_range(1, 5);
      send_consec_addr = 1'($urandom_range(0, 1));
      consec_count = 8'($urandom_range(0, 7));
      exp_q.delete();
      ecyc = 2;
      for (int b = 0; b < nb; b++) begin
        base = $urandom;
        push(base);
        ecyc += 2;
        len = send_consec_addr ? int'(consec_count) + 1 : 1;
        for (int k = 0; k < len; k++) begin
          exp_q.push_back(base + 32'(k * 4));
          s = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
          st_mem[st_wr % TMAX] = s;
          st_wr = st_wr + 1;
          ecyc += s + 1;
        end
      end
      rdy_mode = 1'b1;
      end_program = 1'b1;
      start_run;
      wait_idle(2000, "rnd_timeout");
      scan(c0, cyc);
      cmp_addrs("rnd");
      chk("rnd_issue_cnt", addr_issue_cnt, exp_q.size());
      chk("rnd_cycle_cnt", addr_cycle_cnt, ecyc);
      chk("rnd_rd_count", n_rd, nb);
      chk("rnd_done_count", n_done, 1);
      chk("rnd_unstable", n_unstable, 0);
      chk("rnd_rd_when_empty", n_rd_empty, 0);
    end
    idle_setup;
    adv;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addr_seq_engine.md
Name: addr_seq_engine

Overview:
- Sequencer that drains the driver address FIFO while a program is active and issues vector-memory addresses downstream over a valid/ready handshake.
- Each FIFO word is a base address. When consecutive mode is enabled, the base is expanded into a burst of consec_count+1 addresses.
- Sits between the driver control register block (run/end/abort/freeze/consec controls) and the vector fetch path.
- Reports cycle and issue counters for the status readback.

Parameters:
- ADDR_W, 32, width of FIFO words and issued addresses.
- ADDR_STEP, 4, increment between consecutive burst addresses (bytes).
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- run_program  in  1  start request; sampled in IDLE only.
- end_program  in  1  finish once the FIFO is empty and no burst is pending.
- abort_program  in  1  immediate termination from any non-IDLE state.
- freeze_addr_fifo  in  1  inhibit FIFO reads; an in-flight burst continues.
- send_consec_addr  in  1  enable burst expansion of each base address.
- consec_count  in  8  extra addresses per base (burst length = consec_count+1).
- addr_fifo_dout  in  ADDR_W  FIFO read data, valid 1 cycle after addr_fifo_rd.
- addr_fifo_empty  in  1  FIFO empty flag.
- addr_fifo_rd  out  1  FIFO read strobe, one cycle per word.
- vec_addr  out  ADDR_W  issued address.
- vec_addr_valid  out  1  vec_addr is valid.
- vec_addr_ready  in  1  downstream accepts when valid&&ready.
- seq_busy  out  1  high in any state other than IDLE.
- seq_done  out  1  one-cycle pulse on leaving DONE.
- addr_cycle_cnt  out  CNT_W  cycles spent non-IDLE in the current run.
- addr_issue_cnt  out  CNT_W  addresses accepted downstream in the current run.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0, including vec_addr and both counters.
- States: IDLE, FETCH, LOAD, ISSUE, DONE.
- IDLE:
  - run_program=1 -> FETCH.
  - On that transition, clear addr_cycle_cnt and addr_issue_cnt.
- FETCH:
  - abort_program -> DONE.
  - Else if !addr_fifo_empty && !freeze_addr_fifo: addr_fifo_rd=1 for exactly this cycle -> LOAD.
  - Else if addr_fifo_empty && end_program -> DONE.
  - Else stay in FETCH; addr_fifo_rd=0.
- LOAD:
  - Capture vec_addr <= addr_fifo_dout.
  - Capture remaining <= send_consec_addr ? consec_count : 0. Controls are sampled here only; changes mid-burst have no effect.
  - Then -> ISSUE, or DONE if abort_program.
- ISSUE:
  - vec_addr_valid=1; vec_addr is held stable until accepted.
  - On valid&&ready with remaining==0 -> FETCH.
  - On valid&&ready with remaining!=0: vec_addr <= vec_addr+ADDR_STEP (mod 2^ADDR_W, wraps silently), remaining--, stay in ISSUE. Back-to-back issue of one address per cycle is supported.
  - abort_program: drop vec_addr_valid in the same cycle as the transition -> DONE. An address presented together with abort is not counted and not considered accepted.
- DONE:
  - seq_done=1 for one cycle -> IDLE.
  - run_program asserted in DONE is ignored; it must be seen again in IDLE.
- Latency:
  - run -> first addr_fifo_rd: 1 cycle.
  - addr_fifo_rd -> first vec_addr_valid: 2 cycles (LOAD, then ISSUE).
  - Minimum per-base overhead between bursts: 2 idle cycles (FETCH, LOAD).
- Priority: abort_program > FIFO read > end_program. With end_program and a non-empty FIFO, the FIFO is fully drained first.
- freeze_addr_fifo: only blocks the FETCH->LOAD read. It never stalls ISSUE.
- Counters:
  - addr_cycle_cnt increments every cycle while seq_busy=1.
  - addr_issue_cnt increments on each valid&&ready.
  - Both saturate at all-ones (no wrap).
  - Both hold their values in IDLE for readback.
- vec_addr_valid=0 in every state except ISSUE. addr_fifo_rd is never asserted while addr_fifo_empty=1.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No seq_done pulse.

Test Plan:
- Basic drain: FIFO={0x1000,0x2000}, send_consec_addr=0, ready=1, run pulse then end_program=1 -> vec_addr 0x1000 then 0x2000, two rd strobes, seq_done pulse, addr_issue_cnt=2.
- Burst: FIFO={0x0000_0100}, send_consec_addr=1, consec_count=3, ready=1 -> 0x100,0x104,0x108,0x10C on consecutive cycles, addr_issue_cnt=4.
- Backpressure/wrap: base 0xFFFF_FFFC, consec_count=1, ready low 5 cycles -> 0xFFFF_FFFC held stable with valid high for 5 cycles, then 0x0000_0000 issued.
- Freeze: FIFO non-empty, freeze_addr_fifo=1 for 10 cycles -> no addr_fifo_rd, valid=0, addr_cycle_cnt advances by 10. On release, rd occurs the next cycle.
- Abort mid-burst: consec_count=7, abort asserted after 2 accepts -> valid drops that cycle, seq_done pulses 1 cycle later, addr_issue_cnt=2.
- Reset mid-ISSUE: assert reset asynchronously -> valid, busy and counters are 0 immediately; no seq_done; the next run_program starts cleanly.
